// File: rtl/adder_limb_serial_8u.sv
// rtl/adder_limb_serial_8u.sv - limb-serial WIDTH-bit unsigned adder built on an 8-bit Sklansky adder

// rtl/adder_limb_serial_8u.sv - 8-bit Sklansky parallel-prefix adder, no carry in
module adder_sklansky_8u (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [7:0] g;
    logic [7:0] p;

    // Group generate/propagate terms, named G<hi><lo> for bits [hi:lo]
    logic g10, g32, g54, g76;
    logic p32, p54, p76;
    logic g20, g30, g64, g74;
    logic p64, p74;
    logic g40, g50, g60, g70;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Level 1: span 1
    assign g10 = g[1] | (p[1] & g[0]);
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g54 = g[5] | (p[5] & g[4]);
    assign p54 = p[5] & p[4];
    assign g76 = g[7] | (p[7] & g[6]);
    assign p76 = p[7] & p[6];

    // Level 2: span 2
    assign g20 = g[2] | (p[2] & g10);
    assign g30 = g32  | (p32  & g10);
    assign g64 = g[6] | (p[6] & g54);
    assign p64 = p[6] & p54;
    assign g74 = g76  | (p76  & g54);
    assign p74 = p76  & p54;

    // Level 3: span 4, every upper-half bit fans in from G[3:0]
    assign g40 = g[4] | (p[4] & g30);
    assign g50 = g54  | (p54  & g30);
    assign g60 = g64  | (p64  & g30);
    assign g70 = g74  | (p74  & g30);

    assign sum_o  = p ^ {g60, g50, g40, g30, g20, g10, g[0], 1'b0};
    assign cout_o = g70;
endmodule

// rtl/adder_limb_serial_8u.sv - limb-serial top: one 8-bit limb per clock, LSB first
module adder_limb_serial_8u #(
    parameter  int WIDTH = 32,
    localparam int NLIMB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(NLIMB);

    if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_bad_width
        $error("adder_limb_serial_8u: WIDTH must be a multiple of 8 and at least 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [7:0] s1, s2;
    logic       c1, c2;
    logic       last_limb;

    // Limb sum of the current low limbs, then add the inter-limb carry as an increment
    adder_sklansky_8u u_limb (
        .a_i    (a_q[7:0]),
        .b_i    (b_q[7:0]),
        .sum_o  (s1),
        .cout_o (c1)
    );

    adder_sklansky_8u u_inc (
        .a_i    (s1),
        .b_i    ({7'b0, carry_q}),
        .sum_o  (s2),
        .cout_o (c2)
    );

    assign last_limb = (cnt_q == CW'(NLIMB - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE accepts, RUN walks the limbs, DONE waits for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (last_limb) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // Datapath next state: capture operands on accept, shift one limb out per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d                          = a_q >> 8;
                b_d                          = b_q >> 8;
                sum_d[{cnt_q, 3'b000} +: 8]  = s2;
                carry_d                      = c1 | c2;
                cnt_d                        = cnt_q + 1'b1;
                if (last_limb) begin
                    cout_d = c1 | c2;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_adder_limb_serial_8u.sv
// tb/tb_adder_limb_serial_8u.sv - self-checking bench for adder_limb_serial_8u at WIDTH 32 and 64
module tb_adder_limb_serial_8u;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, sum32;
    logic        cin32 = 1'b0, cout32;

    logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_ready64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0, sum64;
    logic        cin64 = 1'b0, cout64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_limb_serial_8u #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .out_valid(out_valid32),
        .out_ready(out_ready32), .sum(sum32), .cout(cout32)
    );

    adder_limb_serial_8u #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .cin(cin64), .out_valid(out_valid64),
        .out_ready(out_ready64), .sum(sum64), .cout(cout64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete transaction on the 32-bit instance with 'stall' cycles of held-off out_ready
    task automatic run32(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input int stall);
        logic [32:0] ref_full;
        int n;
        ref_full = {1'b0, ia} + {1'b0, ib} + {32'd0, ic};
        @(negedge clk);
        chk({nm, " in_ready idle"}, {63'd0, in_ready32}, 64'd1);
        a32 = ia; b32 = ib; cin32 = ic; in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid32 = 1'b0;
        a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
        n = 0;
        while (!out_valid32 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 64'(n), 64'd4);
        chk({nm, " sum"}, {32'd0, sum32}, {32'd0, ref_full[31:0]});
        chk({nm, " cout"}, {63'd0, cout32}, {63'd0, ref_full[32]});
        for (int s = 0; s < stall; s++) begin
            in_valid32 = 1'($urandom);
            a32 = $urandom; b32 = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk({nm, " stall in_ready"}, {63'd0, in_ready32}, 64'd0);
            chk({nm, " stall out_valid"}, {63'd0, out_valid32}, 64'd1);
            chk({nm, " stall sum"}, {32'd0, sum32}, {32'd0, ref_full[31:0]});
            chk({nm, " stall cout"}, {63'd0, cout32}, {63'd0, ref_full[32]});
        end
        in_valid32 = 1'b0;
        out_ready32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready32 = 1'b0;
        chk({nm, " out_valid after accept"}, {63'd0, out_valid32}, 64'd0);
        chk({nm, " in_ready after accept"}, {63'd0, in_ready32}, 64'd1);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          stall;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc_at[$];
        int ov_cnt;

        vt[0] = '{"small",      32'h0000_0001, 32'h0000_0002, 1'b0, 0,  32'h0000_0003, 1'b0};
        vt[1] = '{"ripple",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1,  32'h0000_0000, 1'b1};
        vt[2] = '{"all_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0,  32'hFFFF_FFFF, 1'b1};
        vt[3] = '{"stall10",    32'h1234_56FF, 32'h0000_0001, 1'b0, 10, 32'h1234_5700, 1'b0};
        vt[4] = '{"msb_carry",  32'h8000_0000, 32'h8000_0000, 1'b0, 2,  32'h0000_0000, 1'b1};
        vt[5] = '{"mid_limbs",  32'h00FF_00FF, 32'h0001_0001, 1'b0, 0,  32'h0100_0100, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset in_ready", {63'd0, in_ready32}, 64'd1);
        chk("reset out_valid", {63'd0, out_valid32}, 64'd0);
        chk("reset sum", {32'd0, sum32}, 64'd0);
        chk("reset cout", {63'd0, cout32}, 64'd0);
        rst = 1'b0;

        // Table: each vector's constant expectation checked directly after the transaction
        foreach (vt[i]) begin
            run32(vt[i].nm, vt[i].a, vt[i].b, vt[i].cin, vt[i].stall);
            chk({vt[i].nm, " table sum"}, {32'd0, sum32}, {32'd0, vt[i].s});
            chk({vt[i].nm, " table cout"}, {63'd0, cout32}, {63'd0, vt[i].co});
        end

        // Back-to-back with out_ready and in_valid held high: one add every 6 cycles
        @(negedge clk);
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; cin32 = 1'b1;
        in_valid32 = 1'b1; out_ready32 = 1'b1;
        ov_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready32) acc_at.push_back(c);
            if (out_valid32) begin
                ov_cnt++;
                chk("b2b sum", {32'd0, sum32}, 64'h0000_0000_FFFF_FFFF);
                chk("b2b cout", {63'd0, cout32}, 64'd1);
            end
        end
        in_valid32 = 1'b0;
        chk("b2b accept count", 64'(acc_at.size()), 64'd3);
        chk("b2b done cycles", 64'(ov_cnt), 64'd3);
        for (int k = 1; k < acc_at.size(); k++)
            chk("b2b period", 64'(acc_at[k] - acc_at[k-1]), 64'd6);
        for (int c = 0; c < 20 && !in_ready32; c++) @(negedge clk);
        out_ready32 = 1'b0;
        chk("b2b drained", {63'd0, in_ready32}, 64'd1);

        // Reset asserted during the second RUN cycle
        @(negedge clk);
        a32 = 32'h1111_1111; b32 = 32'h2222_2222; cin32 = 1'b0; in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre-reset partial limb", {56'd0, sum32[7:0]}, 64'h33);
        rst = 1'b1;
        #1;
        chk("midrst out_valid", {63'd0, out_valid32}, 64'd0);
        chk("midrst in_ready", {63'd0, in_ready32}, 64'd1);
        chk("midrst sum", {32'd0, sum32}, 64'd0);
        chk("midrst cout", {63'd0, cout32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run32("after_reset", 32'd5, 32'd7, 1'b0, 0);
        chk("after_reset value", {32'd0, sum32}, 64'd12);

        // Random regression on both widths in parallel
        fork
            begin
                for (int i = 0; i < 1200; i++)
                    run32("rand32", $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
            end
            begin
                logic [64:0] r;
                logic [63:0] ra, rb;
                logic        rc;
                int          n;
                for (int i = 0; i < 600; i++) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    if (i % 50 == 0) begin
                        ra = '1;
                        rb = 64'd0;
                    end
                    rc = 1'($urandom);
                    r  = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
                    @(negedge clk);
                    chk("rand64 in_ready", {63'd0, in_ready64}, 64'd1);
                    a64 = ra; b64 = rb; cin64 = rc; in_valid64 = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    in_valid64 = 1'b0;
                    n = 0;
                    while (!out_valid64 && n < 40) begin
                        out_ready64 = 1'($urandom);
                        @(posedge clk);
                        n++;
                        @(negedge clk);
                    end
                    out_ready64 = 1'b0;
                    chk("rand64 latency", 64'(n), 64'd8);
                    chk("rand64 sum", sum64, r[63:0]);
                    chk("rand64 cout", {63'd0, cout64}, {63'd0, r[64]});
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    chk("rand64 held sum", sum64, r[63:0]);
                    out_ready64 = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    out_ready64 = 1'b0;
                    chk("rand64 out_valid drop", {63'd0, out_valid64}, 64'd0);
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
